// File: rtl/pool_window_streamer_if.sv
// Signal bundle for pool_window_streamer: map load, pass control, pooling-unit
// handshake and pooled-result stream.
interface pool_window_streamer_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int POOL  = 2,
    parameter int DW    = 12
);
    localparam int N_OUT = (IMG_W / POOL) * (IMG_H / POOL);
    localparam int AW    = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          pool_rst;
    logic [DW-1:0] pool_data;
    logic          pool_end;
    logic          pool_finish;
    logic [DW-1:0] pool_out;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [IW-1:0] res_idx;
    logic          err;

    modport master (
        output wr_en, wr_addr, wr_data, start, pool_finish, pool_out,
        input  busy, done, pool_rst, pool_data, pool_end, res_valid, res_data, res_idx, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, pool_finish, pool_out,
        output busy, done, pool_rst, pool_data, pool_end, res_valid, res_data, res_idx, err
    );
endinterface

// File: rtl/pool_window_streamer.sv
// Walks a stored IMG_W x IMG_H map in POOL x POOL windows, frames each window for the
// max-pooling unit and captures one result per window. Optional: POOL_TIMEOUT_EN.
module pool_window_streamer #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int POOL  = 2,
    parameter int DW    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    pool_window_streamer_if.slave   bus
);
    localparam int OUT_W = IMG_W / POOL;
    localparam int OUT_H = IMG_H / POOL;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int AW    = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int KW    = $clog2(POOL);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRST   = 3'd1,
        S_PRIME  = 3'd2,
        S_STREAM = 3'd3,
        S_END    = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic [DW-1:0]  map_r [IMG_W*IMG_H];
    logic [OXW-1:0] ox_r, ox_s;
    logic [OYW-1:0] oy_r, oy_s;
    logic [IW-1:0]  idx_r, idx_s;
    logic [KW-1:0]  kx_r, kx_s, ky_r, ky_s;
    logic           capture_s;
    logic [DW-1:0]  cap_data_s;
    logic           last_win_s;
    logic           start_ok_s;
    logic [AW-1:0]  rd_addr_s;

    logic           busy_r, done_r, pool_rst_r, pool_end_r, res_valid_r, err_r;
    logic [DW-1:0]  pool_data_r, res_data_r;
    logic [IW-1:0]  res_idx_r;

`ifdef POOL_TIMEOUT_EN
    logic [1:0]     wt_r, wt_s;
    logic           timeout_s;
`endif

    // Next-state, window/sample counter advance and result capture decision
    always_comb begin
        state_s    = state_r;
        ox_s       = ox_r;
        oy_s       = oy_r;
        idx_s      = idx_r;
        kx_s       = kx_r;
        ky_s       = ky_r;
        capture_s  = 1'b0;
        cap_data_s = '0;
        last_win_s = (idx_r == IW'(N_OUT - 1));
        start_ok_s = bus.start && !busy_r;
`ifdef POOL_TIMEOUT_EN
        wt_s       = wt_r;
        timeout_s  = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_s = S_PRST;
                    ox_s    = '0;
                    oy_s    = '0;
                    idx_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRST:  state_s = S_PRIME;
            S_PRIME: begin
                state_s = S_STREAM;
                kx_s    = '0;
                ky_s    = '0;
            end
            S_STREAM: begin
                if (kx_r == KW'(POOL - 1) && ky_r == KW'(POOL - 1)) begin
                    state_s = S_END;
                end else if (kx_r == KW'(POOL - 1)) begin
                    kx_s = '0;
                    ky_s = ky_r + KW'(1);
                end else begin
                    kx_s = kx_r + KW'(1);
                end
            end
            S_END: begin
                state_s = S_WAIT;
`ifdef POOL_TIMEOUT_EN
                wt_s    = 2'd0;
`endif
            end
            S_WAIT: begin
                if (bus.pool_finish) begin
                    capture_s  = 1'b1;
                    cap_data_s = bus.pool_out;
                end else begin
`ifdef POOL_TIMEOUT_EN
                    // A silent pooling unit yields a zero result rather than a stall
                    if (wt_r == 2'd3) begin
                        capture_s = 1'b1;
                        timeout_s = 1'b1;
                    end else begin
                        wt_s = wt_r + 2'd1;
                    end
`else
                    capture_s = 1'b0;
`endif
                end
                if (capture_s) begin
                    if (last_win_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_PRST;
                        idx_s   = idx_r + IW'(1);
                        if (ox_r == OXW'(OUT_W - 1)) begin
                            ox_s = '0;
                            oy_s = oy_r + OYW'(1);
                        end else begin
                            ox_s = ox_r + OXW'(1);
                        end
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Address of the sample that the next STREAM cycle presents
    assign rd_addr_s = AW'((int'(oy_r) * POOL + int'(ky_s)) * IMG_W + int'(ox_r) * POOL + int'(kx_s));

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ox_r    <= '0;
            oy_r    <= '0;
            idx_r   <= '0;
            kx_r    <= '0;
            ky_r    <= '0;
`ifdef POOL_TIMEOUT_EN
            wt_r    <= 2'd0;
`endif
        end else begin
            state_r <= state_s;
            ox_r    <= ox_s;
            oy_r    <= oy_s;
            idx_r   <= idx_s;
            kx_r    <= kx_s;
            ky_r    <= ky_s;
`ifdef POOL_TIMEOUT_EN
            wt_r    <= wt_s;
`endif
        end
    end

    // Map storage: writable only between passes and deliberately kept through reset
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_r) begin
            map_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Outputs are registered from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pool_rst_r  <= 1'b1;
            pool_data_r <= '0;
            pool_end_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_idx_r   <= '0;
            err_r       <= 1'b0;
        end else begin
            busy_r      <= (state_s != S_IDLE) || capture_s;
            done_r      <= capture_s && last_win_s;
            pool_rst_r  <= (state_s == S_PRST);
            pool_end_r  <= (state_s == S_END);
            pool_data_r <= (state_s == S_STREAM) ? map_r[rd_addr_s] : '0;
            res_valid_r <= capture_s;
            if (capture_s) begin
                res_data_r <= cap_data_s;
                res_idx_r  <= idx_r;
            end
`ifdef POOL_TIMEOUT_EN
            if (start_ok_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
`else
            err_r <= 1'b0;
`endif
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pool_rst  = pool_rst_r;
    assign bus.pool_data = pool_data_r;
    assign bus.pool_end  = pool_end_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_idx   = res_idx_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_pool_window_streamer.sv
// Directed bench for pool_window_streamer with a behavioural max-pooling unit.
`timescale 1ns/1ps
module tb_pool_window_streamer;
    localparam int IMG_W = 8, IMG_H = 8, POOL = 2, DW = 12, N_OUT = 16, P = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_window_streamer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .POOL(POOL), .DW(DW)) bus_if ();
    pool_window_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .POOL(POOL), .DW(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    int   vecs = 0, errs = 0;
    int   cyc = 0, base = 0;
    logic mon_clr = 1'b0, chk_frame = 1'b0;
    int   delay_win = -1, delay_amt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pooling unit model: reset, drop first sample, running max, finish after end
    logic [DW-1:0] mx_m = '0;
    logic fin_m = 1'b0, first_m = 1'b0, armed_m = 1'b0;
    int   dly_m = 0, wcnt_m = 0, cur_w_m = 0;
    assign bus_if.pool_finish = fin_m;
    assign bus_if.pool_out    = mx_m;

    always @(posedge clk) begin
        if (mon_clr) wcnt_m <= 0;
        else if (bus_if.pool_rst && bus_if.busy) wcnt_m <= wcnt_m + 1;
        fin_m <= 1'b0;
        if (bus_if.pool_rst) begin
            mx_m <= '0; first_m <= 1'b1; armed_m <= 1'b0; cur_w_m <= wcnt_m;
        end else if (first_m) begin
            first_m <= 1'b0;
        end else begin
            if (bus_if.pool_data > mx_m) mx_m <= bus_if.pool_data;
            if (bus_if.pool_end) begin
                if (cur_w_m == delay_win) begin armed_m <= 1'b1; dly_m <= delay_amt; end
                else fin_m <= 1'b1;
            end else if (armed_m) begin
                if (dly_m == 1) begin fin_m <= 1'b1; armed_m <= 1'b0; end
                dly_m <= dly_m - 1;
            end
        end
    end

    // Monitor: records results, done, busy start and framing errors per pass
    int n_res = 0, n_done = 0, done_cyc = -1, first_busy = -1, n_prst = 0, bad_frame = 0;
    logic err_at_done = 1'b0;
    int r_cyc [N_OUT];
    logic [DW-1:0] r_dat [N_OUT];
    logic [3:0] r_idx [N_OUT];

    always @(negedge clk) begin
        int rel, ph;
        rel = cyc - base;
        if (mon_clr) begin
            n_res = 0; n_done = 0; done_cyc = -1; first_busy = -1; n_prst = 0; bad_frame = 0;
            err_at_done = 1'b0;
            for (int i = 0; i < N_OUT; i++) begin r_cyc[i] = -1; r_dat[i] = '0; r_idx[i] = '0; end
        end else begin
            if (bus_if.res_valid) begin
                if (n_res < N_OUT) begin
                    r_cyc[n_res] = rel; r_dat[n_res] = bus_if.res_data; r_idx[n_res] = bus_if.res_idx;
                end
                n_res++;
            end
            if (bus_if.done) begin n_done++; done_cyc = rel; err_at_done = bus_if.err; end
            if (bus_if.busy && first_busy < 0) first_busy = rel;
            if (bus_if.busy && bus_if.pool_rst) n_prst++;
            if (chk_frame && rel >= 1 && rel <= N_OUT * P) begin
                ph = (rel - 1) % P;
                if ((ph < 2 || ph > 5) && bus_if.pool_data != '0) bad_frame++;
                if ((ph == 0) != bus_if.pool_rst) bad_frame++;
                if ((ph == 6) != bus_if.pool_end) bad_frame++;
            end
        end
    end

    function automatic logic [DW-1:0] exp_ramp(input int i);
        return 12'(16 * (i / 4) + 2 * (i % 4) + 9);
    endfunction

    function automatic int exp_cyc(input int i, input int from, input int shift);
        return 1 + (i + 1) * P + ((i >= from) ? shift : 0);
    endfunction

    task automatic load_map(input bit fff);
        for (int a = 0; a < IMG_W * IMG_H; a++) begin
            @(posedge clk); #1;
            bus_if.wr_en = 1'b1; bus_if.wr_addr = 6'(a);
            bus_if.wr_data = fff ? ((a == 0) ? 12'h000 : 12'hFFF) : 12'(a);
        end
        @(posedge clk); #1;
        bus_if.wr_en = 1'b0;
    endtask

    task automatic do_pass(input int ev_start, input int ev_wr, input int ev_rst);
        int rel;
        @(posedge clk); #1;
        bus_if.start = 1'b1; mon_clr = 1'b1; base = cyc;
        @(posedge clk); #1;
        bus_if.start = 1'b0; mon_clr = 1'b0;
        for (int k = 0; k < 400; k++) begin
            rel = cyc - base;
            bus_if.start = (rel == ev_start);
            if (rel == ev_wr) begin
                bus_if.wr_en = 1'b1; bus_if.wr_addr = 6'd63; bus_if.wr_data = 12'h000;
            end else begin
                bus_if.wr_en = 1'b0;
            end
            if (rel == ev_rst) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; bus_if.start = 1'b0; bus_if.wr_en = 1'b0;
                return;
            end
            if (n_done > 0 && rel > done_cyc) break;
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0; bus_if.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({bus_if.busy, bus_if.done, bus_if.pool_rst, bus_if.pool_data, bus_if.pool_end,
             bus_if.res_valid, bus_if.res_data, bus_if.res_idx, bus_if.err}
            !== {1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_values: got busy=%b done=%b prst=%b pdata=%h pend=%b rv=%b rdata=%h ridx=%0d err=%b, want 0 0 1 000 0 0 000 0 0",
                     bus_if.busy, bus_if.done, bus_if.pool_rst, bus_if.pool_data, bus_if.pool_end,
                     bus_if.res_valid, bus_if.res_data, bus_if.res_idx, bus_if.err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (bus_if.pool_rst !== 1'b0) begin
            errs++; $display("FAIL reset_release_pool_rst: got %b want 0", bus_if.pool_rst);
        end
    endtask

    task automatic test_ramp();
        load_map(1'b0);
        chk_frame = 1'b1;
        do_pass(-1, -1, -1);
        chk_frame = 1'b0;
        vecs++;
        if (n_done != 1 || done_cyc != 129) begin
            errs++; $display("FAIL ramp_done: got count %0d cycle %0d want 1 129", n_done, done_cyc);
        end
        vecs++;
        if (bus_if.busy !== 1'b0 || first_busy != 1) begin
            errs++; $display("FAIL ramp_busy: got after=%b first=%0d want 0 1", bus_if.busy, first_busy);
        end
        vecs++;
        if (n_res != N_OUT || err_at_done !== 1'b0) begin
            errs++; $display("FAIL ramp_count_err: got %0d results err=%b want 16 0", n_res, err_at_done);
        end
        vecs++;
        if (bad_frame != 0 || n_prst != N_OUT) begin
            errs++; $display("FAIL ramp_frame: got %0d framing errors %0d resets want 0 16", bad_frame, n_prst);
        end
        for (int i = 0; i < N_OUT; i++) begin
            vecs++;
            if (r_dat[i] !== exp_ramp(i) || r_idx[i] !== 4'(i) || r_cyc[i] != exp_cyc(i, N_OUT, 0)) begin
                errs++;
                $display("FAIL ramp_res%0d: got data %h idx %0d cyc %0d want %h %0d %0d",
                         i, r_dat[i], r_idx[i], r_cyc[i], exp_ramp(i), i, exp_cyc(i, N_OUT, 0));
            end
        end
    endtask

    task automatic test_all_fff();
        load_map(1'b1);
        chk_frame = 1'b1;
        do_pass(-1, -1, -1);
        chk_frame = 1'b0;
        vecs++;
        if (bad_frame != 0 || n_prst != N_OUT || done_cyc != 129) begin
            errs++;
            $display("FAIL fff_frame: got %0d framing errors %0d resets done %0d want 0 16 129",
                     bad_frame, n_prst, done_cyc);
        end
        for (int i = 0; i < N_OUT; i++) begin
            vecs++;
            if (r_dat[i] !== 12'hFFF || r_idx[i] !== 4'(i)) begin
                errs++; $display("FAIL fff_res%0d: got %h idx %0d want fff %0d", i, r_dat[i], r_idx[i], i);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        load_map(1'b0);
        do_pass(20, 30, -1);
        vecs++;
        if (n_done != 1 || done_cyc != 129 || n_res != N_OUT) begin
            errs++;
            $display("FAIL busy_inputs_done: got %0d done at %0d, %0d results want 1 129 16", n_done, done_cyc, n_res);
        end
        for (int i = 0; i < N_OUT; i++) begin
            vecs++;
            if (r_dat[i] !== exp_ramp(i) || r_cyc[i] != exp_cyc(i, N_OUT, 0)) begin
                errs++;
                $display("FAIL busy_inputs_res%0d: got %h cyc %0d want %h %0d",
                         i, r_dat[i], r_cyc[i], exp_ramp(i), exp_cyc(i, N_OUT, 0));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_pass(-1, -1, 40);
        vecs++;
        if ({bus_if.busy, bus_if.pool_rst, bus_if.res_valid, bus_if.err} !== 4'b0100) begin
            errs++;
            $display("FAIL mid_reset: got busy=%b prst=%b rv=%b err=%b want 0 1 0 0",
                     bus_if.busy, bus_if.pool_rst, bus_if.res_valid, bus_if.err);
        end
        do_pass(-1, -1, -1);
        vecs++;
        if (n_done != 1 || done_cyc != 129) begin
            errs++; $display("FAIL mid_reset_rerun_done: got %0d at %0d want 1 129", n_done, done_cyc);
        end
        for (int i = 0; i < N_OUT; i++) begin
            vecs++;
            if (r_dat[i] !== exp_ramp(i) || r_idx[i] !== 4'(i)) begin
                errs++; $display("FAIL mid_reset_res%0d: got %h idx %0d want %h %0d", i, r_dat[i], r_idx[i], exp_ramp(i), i);
            end
        end
    endtask

    task automatic test_late_finish();
        delay_win = 2; delay_amt = 3;
        do_pass(-1, -1, -1);
        delay_win = -1;
        vecs++;
        if (n_done != 1 || done_cyc != 132 || err_at_done !== 1'b0) begin
            errs++; $display("FAIL late_done: got %0d at %0d err=%b want 1 132 0", n_done, done_cyc, err_at_done);
        end
        for (int i = 0; i < N_OUT; i++) begin
            vecs++;
            if (r_dat[i] !== exp_ramp(i) || r_cyc[i] != exp_cyc(i, 2, 3)) begin
                errs++;
                $display("FAIL late_res%0d: got %h cyc %0d want %h %0d", i, r_dat[i], r_cyc[i], exp_ramp(i), exp_cyc(i, 2, 3));
            end
        end
    endtask

`ifdef POOL_TIMEOUT_EN
    task automatic test_timeout();
        logic [DW-1:0] want;
        delay_win = 5; delay_amt = 100;
        do_pass(-1, -1, -1);
        delay_win = -1;
        vecs++;
        if (n_done != 1 || done_cyc != 132 || err_at_done !== 1'b1 || bus_if.err !== 1'b1) begin
            errs++;
            $display("FAIL timeout_done: got %0d at %0d err=%b/%b want 1 132 1/1", n_done, done_cyc, err_at_done, bus_if.err);
        end
        for (int i = 0; i < N_OUT; i++) begin
            want = (i == 5) ? 12'h000 : exp_ramp(i);
            vecs++;
            if (r_dat[i] !== want || r_idx[i] !== 4'(i) || r_cyc[i] != exp_cyc(i, 5, 3)) begin
                errs++;
                $display("FAIL timeout_res%0d: got %h idx %0d cyc %0d want %h %0d %0d",
                         i, r_dat[i], r_idx[i], r_cyc[i], want, i, exp_cyc(i, 5, 3));
            end
        end
        do_pass(-1, -1, -1);
        vecs++;
        if (err_at_done !== 1'b0 || r_dat[5] !== exp_ramp(5)) begin
            errs++; $display("FAIL timeout_clear: got err=%b res5=%h want 0 %h", err_at_done, r_dat[5], exp_ramp(5));
        end
    endtask
`endif

    initial begin
        bus_if.wr_en = 1'b0; bus_if.wr_addr = 6'd0; bus_if.wr_data = 12'h000; bus_if.start = 1'b0;
        test_reset();
        test_ramp();
        test_all_fff();
        test_ignored_inputs();
        test_mid_reset();
        test_late_finish();
`ifdef POOL_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
